// File: rtl/vga_colorbar_gen_pkg.sv
// Shared definitions for the VGA colour-bar pattern source.
//   - 24-bit {R,G,B} colour constants for the eight vertical bars
//   - pattern encoding (BAR=0, GRAD=1, CHECK=2), also used as the pattern FSM state
//   - checkerboard square size and the position bit that selects the square parity
//   - bar_color(): maps a 3-bit bar index to its colour
package vga_colorbar_gen_pkg;

   localparam logic [23:0] ColWhite   = 24'hFFFFFF;
   localparam logic [23:0] ColYellow  = 24'hFFFF00;
   localparam logic [23:0] ColCyan    = 24'h00FFFF;
   localparam logic [23:0] ColGreen   = 24'h00FF00;
   localparam logic [23:0] ColMagenta = 24'hFF00FF;
   localparam logic [23:0] ColRed     = 24'hFF0000;
   localparam logic [23:0] ColBlue    = 24'h0000FF;
   localparam logic [23:0] ColBlack   = 24'h000000;

   typedef enum logic [1:0] {
      PatBar   = 2'd0,
      PatGrad  = 2'd1,
      PatCheck = 2'd2
   } pattern_e;

   localparam int unsigned CheckSize = 32;
   // Squares are a power of two wide, so parity is a single position bit.
   localparam int unsigned CheckBit  = $clog2(CheckSize);

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] col;
      unique case (idx)
         3'd0: col = ColWhite;
         3'd1: col = ColYellow;
         3'd2: col = ColCyan;
         3'd3: col = ColGreen;
         3'd4: col = ColMagenta;
         3'd5: col = ColRed;
         3'd6: col = ColBlue;
         3'd7: col = ColBlack;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/colorbar_pattern_sel.sv
// Pattern rotation for vga_colorbar_gen: frame counter plus BAR -> GRAD -> CHECK -> BAR FSM.
// Only instantiated when COLORBAR_AUTO_CYCLE_EN is defined.
// Ports:
//   clk        in   pixel clock
//   rst_n      in   synchronous active-low reset
//   frame_end  in   high on the cycle the last pixel of a frame is requested
//   pattern_id out  current pattern (0 BAR, 1 GRAD, 2 CHECK), changes on the frame-end edge
module colorbar_pattern_sel
   import vga_colorbar_gen_pkg::*;
#(
   parameter int unsigned FRAME_HOLD = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_end,
   output logic [1:0] pattern_id
);

   // A one-bit counter still works for FRAME_HOLD=1: it simply stays at zero.
   localparam int unsigned FcntW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   pattern_e         state_q, state_d;
   logic [FcntW-1:0] fcnt_q, fcnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= PatBar;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (frame_end) begin
         if (fcnt_q == FcntW'(FRAME_HOLD - 1)) begin
            fcnt_d = '0;
            unique case (state_q)
               PatBar:   state_d = PatGrad;
               PatGrad:  state_d = PatCheck;
               PatCheck: state_d = PatBar;
               default:  state_d = PatBar;
            endcase
         end else begin
            fcnt_d = fcnt_q + FcntW'(1);
         end
      end
   end

   assign pattern_id = state_q;

endmodule

// File: rtl/vga_colorbar_gen.sv
// Pixel-pattern source feeding a VGA timing driver. Active-area position is tracked only from
// rd_req; each request returns one registered 24-bit pixel one cycle later, so it lands in the
// driver's output register together with the driver's 2-cycle-delayed syncs.
// Patterns: 8 colour bars, grey ramp (x[7:0]), 32x32 checkerboard.
// Build option COLORBAR_AUTO_CYCLE_EN: when defined, the pattern rotates every FRAME_HOLD
// frames; when undefined the pattern is fixed to BAR and pattern_id is tied to 0.
// Ports:
//   clk         in   pixel clock
//   rst_n       in   synchronous active-low reset
//   rd_req      in   pixel request from the driver (active area only)
//   rgb_dout    out  {R,G,B} pixel, registered; zero on cycles without a request
//   frame_done  out  one-cycle pulse after the last pixel of a frame is requested
//   pattern_id  out  current pattern: 0 BAR, 1 GRAD, 2 CHECK
module vga_colorbar_gen
   import vga_colorbar_gen_pkg::*;
#(
   parameter int unsigned H_ACT      = 640,
   parameter int unsigned V_ACT      = 480,
   parameter int unsigned FRAME_HOLD = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_req,
   output logic [23:0] rgb_dout,
   output logic        frame_done,
   output logic [1:0]  pattern_id
);

   // x needs at least 8 bits for the grey ramp, y at least CheckBit+1 for the checkerboard.
   localparam int unsigned XW   = ($clog2(H_ACT) > 8) ? $clog2(H_ACT) : 8;
   localparam int unsigned YW   = ($clog2(V_ACT) > CheckBit) ? $clog2(V_ACT) : CheckBit + 1;
   localparam int unsigned BarW = H_ACT / 8;
   localparam int unsigned BPW  = ($clog2(BarW) > 0) ? $clog2(BarW) : 1;

   if (FRAME_HOLD < 1) begin : g_hold_check
      $error("FRAME_HOLD must be at least 1");
   end

   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [BPW-1:0] bar_pos_q, bar_pos_d;
   logic [2:0]     bar_idx_q, bar_idx_d;
   logic [23:0]    rgb_q, rgb_d;
   logic           frame_done_q;

   logic           x_last, y_last, frame_end;
   logic [23:0]    pix;

   assign x_last    = (x_q == XW'(H_ACT - 1));
   assign y_last    = (y_q == YW'(V_ACT - 1));
   assign frame_end = rd_req & x_last & y_last;

`ifdef COLORBAR_AUTO_CYCLE_EN
   colorbar_pattern_sel #(
      .FRAME_HOLD (FRAME_HOLD)
   ) u_pattern_sel (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_end  (frame_end),
      .pattern_id (pattern_id)
   );
`else
   assign pattern_id = 2'(PatBar);
`endif

   // Position and bar tracking; everything holds while rd_req is low (blanking).
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      bar_pos_d = bar_pos_q;
      bar_idx_d = bar_idx_q;
      if (rd_req) begin
         if (x_last) begin
            x_d       = '0;
            bar_pos_d = '0;
            bar_idx_d = '0;
            y_d       = y_last ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
            if (bar_pos_q == BPW'(BarW - 1)) begin
               bar_pos_d = '0;
               // Saturate so any remainder pixels (H_ACT not a multiple of 8) stay in bar 7.
               if (bar_idx_q != 3'd7) begin
                  bar_idx_d = bar_idx_q + 3'd1;
               end
            end else begin
               bar_pos_d = bar_pos_q + BPW'(1);
            end
         end
      end
   end

   always_comb begin
      pix = ColBlack;
      case (pattern_e'(pattern_id))
         PatBar:   pix = bar_color(bar_idx_q);
         PatGrad:  pix = {x_q[7:0], x_q[7:0], x_q[7:0]};
         PatCheck: pix = (x_q[CheckBit] ^ y_q[CheckBit]) ? ColWhite : ColBlack;
         default:  pix = ColBlack;
      endcase
      rgb_d = rd_req ? pix : ColBlack;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q          <= '0;
         y_q          <= '0;
         bar_pos_q    <= '0;
         bar_idx_q    <= '0;
         rgb_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         bar_pos_q    <= bar_pos_d;
         bar_idx_q    <= bar_idx_d;
         rgb_q        <= rgb_d;
         frame_done_q <= frame_end;
      end
   end

   assign rgb_dout   = rgb_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_colorbar_gen.sv
// Self-checking bench for vga_colorbar_gen on a reduced 264x33 raster with FRAME_HOLD=2.
module tb_vga_colorbar_gen;

   localparam int H  = 264;
   localparam int V  = 33;
   localparam int FH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_req;
   logic [23:0] rgb_dout;
   logic        frame_done;
   logic [1:0]  pattern_id;

   int errors  = 0;
   int checks  = 0;
   int fd_seen = 0;

   // Reference model state: next pixel to be requested and frames completed since reset.
   int mx = 0;
   int my = 0;
   int mframe = 0;

   logic [23:0] bar_tab [8];

   always #5 clk = ~clk;

   vga_colorbar_gen #(
      .H_ACT      (H),
      .V_ACT      (V),
      .FRAME_HOLD (FH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_req     (rd_req),
      .rgb_dout   (rgb_dout),
      .frame_done (frame_done),
      .pattern_id (pattern_id)
   );

   function automatic int pat_of(input int frames);
`ifdef COLORBAR_AUTO_CYCLE_EN
      return (frames / FH) % 3;
`else
      return 0;
`endif
   endfunction

   function automatic logic [23:0] ref_pix(input int x, input int y, input int pat);
      int idx;
      logic [7:0] g;
      idx = x / (H / 8);
      if (idx > 7) idx = 7;
      g = 8'(x % 256);
      case (pat)
         0:       return bar_tab[idx];
         1:       return {g, g, g};
         2:       return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
         default: return 24'h000000;
      endcase
   endfunction

   // One clock: drive rd_req, advance the model, then check the registered outputs.
   task automatic step(input logic r, input string tag);
      logic [23:0] e_rgb;
      logic        e_fd;
      int          e_pat, px, py;
      px    = mx;
      py    = my;
      e_rgb = r ? ref_pix(mx, my, pat_of(mframe)) : 24'h000000;
      e_fd  = 1'b0;
      if (r) begin
         if (mx == H - 1) begin
            mx = 0;
            if (my == V - 1) begin
               my = 0;
               mframe++;
               e_fd = 1'b1;
            end else begin
               my++;
            end
         end else begin
            mx++;
         end
      end
      e_pat  = pat_of(mframe);
      rd_req = r;
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_seen++;
      checks++;
      if (rgb_dout !== e_rgb) begin
         errors++;
         $display("FAIL %s rgb at (%0d,%0d) req=%0b: got %h want %h",
                  tag, px, py, r, rgb_dout, e_rgb);
      end
      checks++;
      if (frame_done !== e_fd) begin
         errors++;
         $display("FAIL %s frame_done at (%0d,%0d): got %b want %b", tag, px, py, frame_done, e_fd);
      end
      checks++;
      if (pattern_id !== 2'(e_pat)) begin
         errors++;
         $display("FAIL %s pattern_id at (%0d,%0d): got %0d want %0d",
                  tag, px, py, pattern_id, e_pat);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (rgb_dout !== 24'h0) begin
         errors++;
         $display("FAIL %s rgb: got %h want 000000", tag, rgb_dout);
      end
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL %s frame_done: got %b want 0", tag, frame_done);
      end
      checks++;
      if (pattern_id !== 2'd0) begin
         errors++;
         $display("FAIL %s pattern_id: got %0d want 0", tag, pattern_id);
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      rd_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      mx = 0;
      my = 0;
      mframe = 0;
      rst_n = 1'b1;
   endtask

   task automatic test_bar_line();
      for (int i = 0; i < H; i++) step(1'b1, "bar_line0");
   endtask

   task automatic test_blanking();
      for (int i = 0; i < 160; i++) step(1'b0, "blanking");
      for (int i = 0; i < H; i++) step(1'b1, "bar_line1");
   endtask

   task automatic test_random_gaps();
      int fd0, budget;
      fd0 = fd_seen;
      budget = 40000;
      while (mframe == 0 && budget > 0) begin
         step($urandom_range(15) != 0, "gaps");
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL gaps_timeout: frame end not reached, frames=%0d want 1", mframe);
      end
      checks++;
      if (fd_seen - fd0 != 1) begin
         errors++;
         $display("FAIL gaps_frame_done_count: got %0d want 1", fd_seen - fd0);
      end
   endtask

   task automatic test_mid_reset();
      int budget;
      budget = 30000;
      while (!(mframe == 2 && mx == 100 && my == 20) && budget > 0) begin
         step(1'b1, "pre_reset");
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL mid_reset_timeout: at (%0d,%0d) frame %0d", mx, my, mframe);
      end
      // Reset must take priority over a coincident request.
      rst_n  = 1'b0;
      rd_req = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("mid_reset");
      rst_n  = 1'b1;
      mx = 0;
      my = 0;
      mframe = 0;
      step(1'b1, "after_reset");
      checks++;
      if (rgb_dout !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL after_reset_pixel00: got %h want FFFFFF", rgb_dout);
      end
   endtask

   task automatic test_back_to_back_rotation();
      int fd0, budget;
      fd0 = fd_seen;
      budget = 60000;
      while (!(mframe == 6 && my == 2) && budget > 0) begin
         step(1'b1, "rotation");
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL rotation_timeout: frames=%0d want 6", mframe);
      end
      checks++;
      if (fd_seen - fd0 != 6) begin
         errors++;
         $display("FAIL rotation_frame_done_count: got %0d want 6", fd_seen - fd0);
      end
      checks++;
      if (pattern_id !== 2'd0) begin
         errors++;
         $display("FAIL frame6_pattern: got %0d want 0", pattern_id);
      end
   endtask

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bar_tab[0] = 24'hFFFFFF;
      bar_tab[1] = 24'hFFFF00;
      bar_tab[2] = 24'h00FFFF;
      bar_tab[3] = 24'h00FF00;
      bar_tab[4] = 24'hFF00FF;
      bar_tab[5] = 24'hFF0000;
      bar_tab[6] = 24'h0000FF;
      bar_tab[7] = 24'h000000;
      rst_n  = 1'b0;
      rd_req = 1'b0;
      test_reset();
      test_bar_line();
      test_blanking();
      test_random_gaps();
      test_mid_reset();
      test_back_to_back_rotation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
